mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified SRAM port between instruction fetch (IF) and the MEM-stage data access.
//  Sequences each multi-cycle SRAM access and returns a one-cycle ready pulse to the granted requester.
//  Raises per-requester stall requests, which the pipeline stall logic turns into PC/IFID holds or full-pipe holds.
// PARAMETERS
//  ADDR_W       32  address width, byte address
//  DATA_W       32  data width
//  WAIT_CYCLES  2   cycles sram_ce is held per access; legal range >=1
// PORTS
//  clk          in   1         single clock, rising edge
//  rst          in   1         synchronous, active-high reset
//  if_req       in   1         IF access request; held with if_addr until if_ready
//  if_addr      in   ADDR_W    IF fetch address
//  if_rdata     out  DATA_W    fetched word; valid while if_ready=1, held until the next IF capture
//  if_ready     out  1         one-cycle completion pulse for IF
//  mem_req      in   1         MEM-stage request; held with the mem_* payload until mem_ready
//  mem_we       in   1         1=store, 0=load
//  mem_be       in   DATA_W/8  byte enables for stores
//  mem_addr     in   ADDR_W    data address
//  mem_wdata    in   DATA_W    store data
//  mem_rdata    out  DATA_W    load data; valid while mem_ready=1, held until the next MEM load capture
//  mem_ready    out  1         one-cycle completion pulse for MEM (loads and stores)
//  sram_ce      out  1         SRAM chip enable, registered
//  sram_we      out  1         SRAM write enable, registered
//  sram_be      out  DATA_W/8  SRAM byte enables, registered
//  sram_addr    out  ADDR_W    SRAM address, registered
//  sram_wdata   out  DATA_W    SRAM write data, registered
//  sram_rdata   in   DATA_W    SRAM read data, sampled on the last access cycle
//  stall_if     out  1         if_req & ~if_ready (combinational)
//  stall_mem    out  1         mem_req & ~mem_ready (combinational)
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, last_grant=IF. Every registered output is 0, including rdata regs.
//  - A reset mid-access aborts the access. No ready pulse is produced, and sram_* read 0 the cycle after reset.
//  - FSM: IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE: if any req is high, latch the grant and payload and go to ACCESS; otherwise stay.
//  - Grant rule: only mem_req -> MEM; only if_req -> IF.
//  - Grant rule, both high: MEM, unless last_grant=MEM, in which case IF (anti-starvation). last_grant updates on every grant.
//  - ACCESS lasts exactly WAIT_CYCLES cycles. sram_ce=1 throughout, and the payload stays stable. sram_we=mem_we & (grant==MEM).
//  - Counter loads WAIT_CYCLES-1 and decrements; at 0, sample sram_rdata (reads only) and go to DONE.
//  - DONE: sram_ce=0, and the granted ready=1 for exactly this cycle; next state is IDLE. Requests are not granted in DONE.
//  - Latency: req first seen in IDLE at cycle 0. ACCESS covers cycles 1..WAIT_CYCLES. Ready is high at cycle WAIT_CYCLES+1.
//    Back-to-back accesses have a period of WAIT_CYCLES+2.
//  - No preemption: an IF access in flight completes even if mem_req rises, and MEM is granted at the next IDLE.
//  - A req dropped mid-access (e.g. on pipeline flush) does not abort. The access completes, and the ready pulse still fires and is ignored.
//  - A req still high in IDLE always starts a new access. Requesters drop or update req the cycle after ready.
//  - Stores: mem_rdata is not updated; mem_ready pulses as for loads.
//  - Width: sram_be is all-ones for IF reads; for MEM it is mem_be (a load ignores be).
// STRUCTURE
//  - Shared package: state encoding (IDLE/ACCESS/DONE), grant IDs (GNT_IF/GNT_MEM), default WAIT_CYCLES.
//  - One sub-module: mem_wait_counter, a loadable down-counter with a zero flag, width $clog2(WAIT_CYCLES)+1.
//  - Top level holds the FSM, grant/last_grant regs, payload regs and rdata capture regs.
// TESTING
//  1. rst held 3 cycles, with both reqs high -> all outputs 0. First grant is to MEM at the cycle after rst falls.
//  2. IF read: if_req=1, addr=0x0000_0040, sram returns 0x2408_0005 -> ACCESS cycles 1-2, if_ready=1 and if_rdata=0x2408_0005 at cycle 3, stall_if=1 in cycles 0-2.
//  3. Simultaneous reqs, both held -> grant order MEM, IF, MEM, IF. Ready pulses at cycles 3, 7, 11, 15 (WAIT_CYCLES=2).
//  4. Store: mem_we=1, be=4'b0011, addr=0x100, wdata=0xDEAD_BEEF -> sram_we=1 and be=0011 for 2 cycles. mem_rdata unchanged, mem_ready pulses once.
//  5. mem_req rises at IF ACCESS cycle 1 -> IF completes uninterrupted, and the MEM ACCESS starts 2 cycles after if_ready.
//  6. rst asserted during ACCESS cycle 1 -> no ready pulse, sram_ce=0 the next cycle, FSM in IDLE; WAIT_CYCLES=1 variant rerun of test 2 with ready at cycle 2.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified SRAM port arbiter: FSM state codes,
// grant identifiers and the round-robin tie-break helper.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;

    localparam int DEFAULT_WAIT_CYCLES = 2;

    // MEM wins a tie unless it also won the previous grant, so IF cannot starve.
    function automatic logic pick_grant(input logic if_req, input logic mem_req,
                                        input logic last_grant);
        if (if_req && mem_req)
            return (last_grant == GNT_MEM) ? GNT_IF : GNT_MEM;
        else if (mem_req)
            return GNT_MEM;
        else
            return GNT_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait.sv
// Loadable down-counter timing the SRAM access phase; zero marks the last
// access cycle.
module mem_wait_counter #(
    parameter  int WAIT_CYCLES = 2,
    localparam int CNT_W       = $clog2(WAIT_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= CNT_W'(WAIT_CYCLES - 1);
        else if (dec && (count != '0))
            count <= count - CNT_W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single SRAM port between instruction fetch and MEM-stage
// data accesses, sequencing each access and pulsing ready on completion.
//
// state  | meaning
// IDLE   | port free; grant and latch payload when any request is present
// ACCESS | sram_ce held for WAIT_CYCLES; read data sampled on the last cycle
// DONE   | ready pulse to the granted requester; no new grant this cycle
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [DATA_W/8-1:0] mem_be,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_ready,
    output logic                sram_ce,
    output logic                sram_we,
    output logic [DATA_W/8-1:0] sram_be,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata,
    output logic                stall_if,
    output logic                stall_mem
);

    logic [1:0] state;
    logic       grant;
    logic       last_grant;
    logic       next_grant;
    logic       start;
    logic       cnt_zero;

    assign next_grant = pick_grant(if_req, mem_req, last_grant);
    assign start      = (state == ST_IDLE) && (if_req || mem_req);

    mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (start),
        .dec  (state == ST_ACCESS),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= GNT_IF;
            last_grant <= GNT_IF;
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_be    <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_ACCESS;
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        sram_ce    <= 1'b1;
                        if (next_grant == GNT_MEM) begin
                            sram_we    <= mem_we;
                            sram_be    <= mem_be;
                            sram_addr  <= mem_addr;
                            sram_wdata <= mem_wdata;
                        end else begin
                            sram_we    <= 1'b0;
                            sram_be    <= '1;
                            sram_addr  <= if_addr;
                            sram_wdata <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_zero) begin
                        state   <= ST_DONE;
                        sram_ce <= 1'b0;
                        sram_we <= 1'b0;
                        // the latched sram_we tells a store from a load
                        if (grant == GNT_MEM) begin
                            mem_ready <= 1'b1;
                            if (!sram_we)
                                mem_rdata <= sram_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= sram_rdata;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = mem_req & ~mem_ready;

endmodule
